// File: rtl/uart_cmd_pkg.sv
// Shared types and default sizes for the UART command assembler.
// Referenced by uart_cmd_assembler; the CMD_TIMEOUT_EN build also uses cmd_timeout_cnt.
package uart_cmd_pkg;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        READY   = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_NUM_BYTES = 2;

endpackage

// File: rtl/cmd_timeout_cnt.sv
// Idle-cycle counter that flags an abandoned partial frame.
// Compiled only when CMD_TIMEOUT_EN is defined.
`ifdef CMD_TIMEOUT_EN
module cmd_timeout_cnt #(
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] timer;

    // The timeout fires on the idle cycle that follows a count of TIMEOUT_CYC-1.
    assign expire = run && !clr && (timer == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer <= '0;
        end else if (clr || expire) begin
            timer <= '0;
        end else if (run) begin
            timer <= timer + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/uart_cmd_assembler.sv
// Packs NUM_BYTES received bytes into one command word, first byte most significant.
// Define CMD_TIMEOUT_EN to discard partial frames that stay idle for TIMEOUT_CYC clocks.
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int NUM_BYTES   = DEFAULT_NUM_BYTES,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_rdy,
    input  logic [DATA_W-1:0]             rx_data,
    input  logic                          clr_cmd_rdy,
    output logic [NUM_BYTES*DATA_W-1:0]   cmd,
    output logic                          cmd_rdy,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int CMD_W = NUM_BYTES * DATA_W;
    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    if (NUM_BYTES < 1 || NUM_BYTES > 16 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_cmd_assembler: NUM_BYTES must be 1..16 and TIMEOUT_CYC at least 2");
    end

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] base_cnt;
    logic [CMD_W-1:0] cmd_shift;
    logic             accept;
    logic             timeout_expire;

    if (NUM_BYTES == 1) begin : g_single
        assign cmd_shift = rx_data;
    end else begin : g_multi
        assign cmd_shift = {cmd[CMD_W-DATA_W-1:0], rx_data};
    end

    // An acknowledge restarts the frame, so a byte arriving with it is always byte 0.
    assign base_cnt = clr_cmd_rdy ? '0 : byte_cnt;
    assign accept   = rx_rdy && ((state == COLLECT) || clr_cmd_rdy);

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    ((state == COLLECT) && (byte_cnt != '0) && !rx_rdy),
        .clr    (rx_rdy || clr_cmd_rdy),
        .expire (timeout_expire)
    );
`else
    assign timeout_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            byte_cnt  <= '0;
            cmd       <= '0;
            cmd_rdy   <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= timeout_expire;
            if (accept) begin
                cmd <= cmd_shift;
                if (base_cnt == LAST_CNT) begin
                    byte_cnt <= '0;
                    cmd_rdy  <= 1'b1;
                    state    <= READY;
                end else begin
                    byte_cnt <= base_cnt + 1'b1;
                    cmd_rdy  <= 1'b0;
                    state    <= COLLECT;
                end
            end else if (clr_cmd_rdy) begin
                byte_cnt <= '0;
                cmd_rdy  <= 1'b0;
                state    <= COLLECT;
            end else if ((state == READY) && rx_rdy) begin
                overrun <= 1'b1;
            end else if (timeout_expire) begin
                byte_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed self-checking bench for uart_cmd_assembler (2-byte and 4-byte instances).
// Timeout expectations follow whether CMD_TIMEOUT_EN is defined for the build.
module tb_uart_cmd_assembler;

`ifdef CMD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        rx_rdy2 = 1'b0;
    logic [7:0]  rx_data2 = '0;
    logic        clr2 = 1'b0;
    logic [15:0] cmd2;
    logic        cmd_rdy2, overrun2, frame_err2;

    logic        rx_rdy4 = 1'b0;
    logic [7:0]  rx_data4 = '0;
    logic        clr4 = 1'b0;
    logic [31:0] cmd4;
    logic        cmd_rdy4, overrun4, frame_err4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    uart_cmd_assembler #(.DATA_W(8), .NUM_BYTES(2), .TIMEOUT_CYC(16)) dut2 (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy2),
        .rx_data     (rx_data2),
        .clr_cmd_rdy (clr2),
        .cmd         (cmd2),
        .cmd_rdy     (cmd_rdy2),
        .overrun     (overrun2),
        .frame_err   (frame_err2)
    );

    uart_cmd_assembler #(.DATA_W(8), .NUM_BYTES(4), .TIMEOUT_CYC(16)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .rx_rdy      (rx_rdy4),
        .rx_data     (rx_data4),
        .clr_cmd_rdy (clr4),
        .cmd         (cmd4),
        .cmd_rdy     (cmd_rdy4),
        .overrun     (overrun4),
        .frame_err   (frame_err4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send2(input logic [7:0] b);
        rx_data2 = b;
        rx_rdy2  = 1'b1;
        tick(1);
        rx_rdy2  = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        rx_data4 = b;
        rx_rdy4  = 1'b1;
        tick(1);
        rx_rdy4  = 1'b0;
    endtask

    task automatic clear2();
        clr2 = 1'b1;
        tick(1);
        clr2 = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(3);
        check("rst_cmd2", cmd2, 32'h0);
        check("rst_rdy2", cmd_rdy2, 1'b0);
        check("rst_ovr2", overrun2, 1'b0);
        check("rst_ferr2", frame_err2, 1'b0);
        check("rst_cmd4", cmd4, 32'h0);
        check("rst_rdy4", cmd_rdy4, 1'b0);
        rst = 1'b0;
        tick(1);

        // Two bytes five cycles apart
        send2(8'hA5);
        check("t1_partial_cmd", cmd2, 32'h00A5);
        check("t1_partial_rdy", cmd_rdy2, 1'b0);
        tick(5);
        send2(8'h3C);
        check("t1_cmd", cmd2, 32'hA53C);
        check("t1_rdy", cmd_rdy2, 1'b1);
        clear2();
        check("t1_clr_rdy", cmd_rdy2, 1'b0);
        check("t1_clr_cmd_held", cmd2, 32'hA53C);

        // Four back-to-back bytes, then an overrun
        send4(8'h01);
        send4(8'h02);
        send4(8'h03);
        check("t2_rdy_before_last", cmd_rdy4, 1'b0);
        send4(8'h04);
        check("t2_cmd", cmd4, 32'h01020304);
        check("t2_rdy", cmd_rdy4, 1'b1);
        send4(8'hFF);
        check("t2_overrun", overrun4, 1'b1);
        check("t2_cmd_held", cmd4, 32'h01020304);
        check("t2_rdy_held", cmd_rdy4, 1'b1);
        tick(1);
        check("t2_overrun_pulse", overrun4, 1'b0);

        // Acknowledge and new byte in the same cycle
        send2(8'h10);
        send2(8'h20);
        check("t3_setup_rdy", cmd_rdy2, 1'b1);
        clr2     = 1'b1;
        rx_data2 = 8'h77;
        rx_rdy2  = 1'b1;
        tick(1);
        clr2     = 1'b0;
        rx_rdy2  = 1'b0;
        check("t3_rdy", cmd_rdy2, 1'b0);
        check("t3_no_overrun", overrun2, 1'b0);
        check("t3_cmd_shift", cmd2, 32'h2077);
        send2(8'h88);
        check("t3_cmd", cmd2, 32'h7788);
        check("t3_rdy_set", cmd_rdy2, 1'b1);
        clear2();

        // Partial frame discarded by acknowledge
        send2(8'h11);
        clear2();
        send2(8'h22);
        check("t4_rdy_after_22", cmd_rdy2, 1'b0);
        send2(8'h33);
        check("t4_cmd", cmd2, 32'h2233);
        check("t4_rdy", cmd_rdy2, 1'b1);
        clear2();

        // Abandoned byte followed by 16 idle cycles
        send2(8'h55);
        tick(15);
        check("t5_ferr_early", frame_err2, 1'b0);
        tick(1);
        check("t5_ferr", frame_err2, TO_EN);
        tick(1);
        check("t5_ferr_pulse", frame_err2, 1'b0);
        send2(8'hAA);
        check("t5_cmd_aa", cmd2, 32'h55AA);
        check("t5_rdy_aa", cmd_rdy2, !TO_EN);
        send2(8'hBB);
        check("t5_cmd_bb", cmd2, TO_EN ? 32'hAABB : 32'h55AA);
        check("t5_rdy_bb", cmd_rdy2, 1'b1);
        check("t5_ovr_bb", overrun2, !TO_EN);
        check("t5_no_ferr4", frame_err4, 1'b0);
        clear2();

        // Asynchronous reset mid-frame; dut4 is still holding a command
        send2(8'h99);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_cmd2", cmd2, 32'h0);
        check("t6_async_rdy4", cmd_rdy4, 1'b0);
        check("t6_async_cmd4", cmd4, 32'h0);
        #1;
        rst = 1'b0;
        send2(8'h12);
        check("t6_cmd_12", cmd2, 32'h0012);
        check("t6_rdy_12", cmd_rdy2, 1'b0);
        send2(8'h34);
        check("t6_cmd", cmd2, 32'h1234);
        check("t6_rdy", cmd_rdy2, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
